// File: rtl/wb_scoreboard_ctrl.sv
// Register-hazard scoreboard plus single-port writeback sequencer between issue and the register file.
// Main and special writeback results are serialised onto one registered write port.
module wb_scoreboard_ctrl #(
   parameter int NUM_REGS     = 16,
   parameter int DATA_WIDTH   = 64,
   parameter int MAX_INFLIGHT = 4,
   localparam int AW = $clog2(NUM_REGS),
   localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid_in,
   input  logic [AW-1:0]         issue_src1_in,
   input  logic [AW-1:0]         issue_src2_in,
   input  logic                  issue_src1_valid_in,
   input  logic                  issue_src2_valid_in,
   input  logic [AW-1:0]         issue_dest_in,
   input  logic                  issue_dest_valid_in,
   input  logic [AW-1:0]         issue_dest_special_in,
   input  logic                  issue_dest_special_valid_in,
   output logic                  issue_grant_out,
   input  logic                  wb_valid_in,
   input  logic                  wb_kill_in,
   input  logic [AW-1:0]         wb_dest_in,
   input  logic [AW-1:0]         wb_dest_special_in,
   input  logic                  wb_dest_special_valid_in,
   input  logic [DATA_WIDTH-1:0] wb_result_in,
   input  logic [DATA_WIDTH-1:0] wb_result_special_in,
   output logic                  wb_ready_out,
   input  logic                  flush_in,
   output logic                  rf_we_out,
   output logic [AW-1:0]         rf_waddr_out,
   output logic [DATA_WIDTH-1:0] rf_wdata_out,
   output logic [NUM_REGS-1:0]   busy_map_out,
   output logic [IW-1:0]         inflight_out,
   output logic                  halt_out,
   output logic [1:0]            state_dbg_out
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_WB_SPECIAL = 2'd1;
   localparam logic [1:0] S_HALTED     = 2'd2;
   localparam logic [IW-1:0] MAX_CNT   = IW'(MAX_INFLIGHT);

   logic [1:0]            state_q, state_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic [IW-1:0]         inflight_q, inflight_d;
   logic                  halt_q, halt_d;
   logic                  rf_we_q, rf_we_d;
   logic [AW-1:0]         rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic [AW-1:0]         spec_addr_q, spec_addr_d;
   logic [DATA_WIDTH-1:0] spec_data_q, spec_data_d;
   logic                  hazard;
   logic                  wb_accept;

   // Hazards look only at the registered busy map: no same-cycle bypass of a clearing bit.
   always_comb begin
      hazard = (issue_src1_valid_in && busy_q[issue_src1_in])
            || (issue_src2_valid_in && busy_q[issue_src2_in])
            || (issue_dest_valid_in && busy_q[issue_dest_in])
            || (issue_dest_special_valid_in && busy_q[issue_dest_special_in]);
   end

   assign issue_grant_out = issue_valid_in && (state_q != S_HALTED) && !flush_in
                         && (inflight_q < MAX_CNT) && !hazard;
   assign wb_ready_out    = (state_q == S_IDLE) && !flush_in;
   assign wb_accept       = wb_valid_in && wb_ready_out;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      inflight_d  = inflight_q;
      halt_d      = halt_q;
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      spec_addr_d = spec_addr_q;
      spec_data_d = spec_data_q;
      if (flush_in) begin
         busy_d     = '0;
         inflight_d = '0;
         if (state_q != S_HALTED) state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wb_accept) begin
                  if (wb_kill_in) begin
                     state_d = S_HALTED;
                     halt_d  = 1'b1;
                  end else begin
                     rf_we_d            = 1'b1;
                     rf_waddr_d         = wb_dest_in;
                     rf_wdata_d         = wb_result_in;
                     busy_d[wb_dest_in] = 1'b0;
                     // A special target equal to the main one collapses into the main write.
                     if (wb_dest_special_valid_in && (wb_dest_special_in != wb_dest_in)) begin
                        spec_addr_d = wb_dest_special_in;
                        spec_data_d = wb_result_special_in;
                        state_d     = S_WB_SPECIAL;
                     end
                  end
               end
            end
            S_WB_SPECIAL: begin
               rf_we_d             = 1'b1;
               rf_waddr_d          = spec_addr_q;
               rf_wdata_d          = spec_data_q;
               busy_d[spec_addr_q] = 1'b0;
               state_d             = S_IDLE;
            end
            default: ;
         endcase
         // Applied after the clears so a same-edge set wins.
         if (issue_grant_out) begin
            if (issue_dest_valid_in)         busy_d[issue_dest_in]         = 1'b1;
            if (issue_dest_special_valid_in) busy_d[issue_dest_special_in] = 1'b1;
         end
         if (issue_grant_out && !wb_accept) begin
            inflight_d = inflight_q + 1'b1;
         end else if (!issue_grant_out && wb_accept && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         busy_q      <= '0;
         inflight_q  <= '0;
         halt_q      <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         spec_addr_q <= '0;
         spec_data_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         inflight_q  <= inflight_d;
         halt_q      <= halt_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         spec_addr_q <= spec_addr_d;
         spec_data_q <= spec_data_d;
      end
   end

   assign rf_we_out     = rf_we_q;
   assign rf_waddr_out  = rf_waddr_q;
   assign rf_wdata_out  = rf_wdata_q;
   assign busy_map_out  = busy_q;
   assign inflight_out  = inflight_q;
   assign halt_out      = halt_q;
   assign state_dbg_out = state_q;

endmodule

// File: tb/tb_wb_scoreboard_ctrl.sv
// Self-checking bench for wb_scoreboard_ctrl: directed scenarios plus a randomized run
// compared against a register-level behavioural model.
module tb_wb_scoreboard_ctrl;

   localparam int AW = 4;
   localparam int DW = 64;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          issue_valid_in, issue_src1_valid_in, issue_src2_valid_in;
   logic [AW-1:0] issue_src1_in, issue_src2_in, issue_dest_in, issue_dest_special_in;
   logic          issue_dest_valid_in, issue_dest_special_valid_in;
   logic          issue_grant_out;
   logic          wb_valid_in, wb_kill_in, wb_dest_special_valid_in;
   logic [AW-1:0] wb_dest_in, wb_dest_special_in;
   logic [DW-1:0] wb_result_in, wb_result_special_in;
   logic          wb_ready_out;
   logic          flush_in;
   logic          rf_we_out;
   logic [AW-1:0] rf_waddr_out;
   logic [DW-1:0] rf_wdata_out;
   logic [NR-1:0] busy_map_out;
   logic [2:0]    inflight_out;
   logic          halt_out;
   logic [1:0]    state_dbg_out;

   int checks = 0;
   int passes = 0;
   logic [AW+DW-1:0] exp_q[$];

   wb_scoreboard_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .issue_valid_in(issue_valid_in), .issue_src1_in(issue_src1_in), .issue_src2_in(issue_src2_in),
      .issue_src1_valid_in(issue_src1_valid_in), .issue_src2_valid_in(issue_src2_valid_in),
      .issue_dest_in(issue_dest_in), .issue_dest_valid_in(issue_dest_valid_in),
      .issue_dest_special_in(issue_dest_special_in), .issue_dest_special_valid_in(issue_dest_special_valid_in),
      .issue_grant_out(issue_grant_out),
      .wb_valid_in(wb_valid_in), .wb_kill_in(wb_kill_in), .wb_dest_in(wb_dest_in),
      .wb_dest_special_in(wb_dest_special_in), .wb_dest_special_valid_in(wb_dest_special_valid_in),
      .wb_result_in(wb_result_in), .wb_result_special_in(wb_result_special_in),
      .wb_ready_out(wb_ready_out), .flush_in(flush_in),
      .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
      .busy_map_out(busy_map_out), .inflight_out(inflight_out), .halt_out(halt_out),
      .state_dbg_out(state_dbg_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      issue_valid_in = 0; issue_src1_valid_in = 0; issue_src2_valid_in = 0;
      issue_src1_in = 0; issue_src2_in = 0; issue_dest_in = 0; issue_dest_special_in = 0;
      issue_dest_valid_in = 0; issue_dest_special_valid_in = 0;
      wb_valid_in = 0; wb_kill_in = 0; wb_dest_in = 0; wb_dest_special_in = 0;
      wb_dest_special_valid_in = 0; wb_result_in = 0; wb_result_special_in = 0;
      flush_in = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_issue(input logic [AW-1:0] d, input logic dv,
                              input logic [AW-1:0] s1, input logic s1v);
      issue_valid_in = 1; issue_dest_in = d; issue_dest_valid_in = dv;
      issue_src1_in = s1; issue_src1_valid_in = s1v;
   endtask

   task automatic drive_wb(input logic [AW-1:0] d, input logic [AW-1:0] sp, input logic spv,
                           input logic [DW-1:0] r, input logic [DW-1:0] rs, input logic kill);
      wb_valid_in = 1; wb_dest_in = d; wb_dest_special_in = sp; wb_dest_special_valid_in = spv;
      wb_result_in = r; wb_result_special_in = rs; wb_kill_in = kill;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clr_inputs();
      reset_n = 0;
      #2;
      checks++; if (rf_we_out !== 1'b0) $display("FAIL reset_we got %0b exp 0", rf_we_out); else passes++;
      checks++; if (busy_map_out !== 16'h0) $display("FAIL reset_busy got %h exp 0", busy_map_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL reset_inflight got %0d exp 0", inflight_out); else passes++;
      checks++; if (halt_out !== 1'b0) $display("FAIL reset_halt got %0b exp 0", halt_out); else passes++;
      checks++; if ({rf_waddr_out, rf_wdata_out} !== '0) $display("FAIL reset_addr_data got %h/%h exp 0", rf_waddr_out, rf_wdata_out); else passes++;
      checks++; if (wb_ready_out !== 1'b1) $display("FAIL reset_ready got %0b exp 1", wb_ready_out); else passes++;
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   task automatic test_hazard();
      drive_issue(4'd3, 1, 4'd0, 0);
      #1;
      checks++; if (issue_grant_out !== 1'b1) $display("FAIL hz_first_grant got %0b exp 1", issue_grant_out); else passes++;
      tick(); clr_inputs();
      checks++; if (busy_map_out !== 16'h0008) $display("FAIL hz_busy_set got %h exp 0008", busy_map_out); else passes++;
      drive_issue(4'd0, 0, 4'd3, 1);
      drive_wb(4'd3, 4'd0, 0, 64'h1234, 64'h0, 0);
      #1;
      checks++; if (issue_grant_out !== 1'b0) $display("FAIL hz_dep_blocked got %0b exp 0", issue_grant_out); else passes++;
      tick();
      wb_valid_in = 0;
      #1;
      checks++; if ({rf_we_out, rf_waddr_out, rf_wdata_out} !== {1'b1, 4'd3, 64'h1234})
         $display("FAIL hz_write got we=%0b a=%0d d=%h exp we=1 a=3 d=1234", rf_we_out, rf_waddr_out, rf_wdata_out); else passes++;
      checks++; if (busy_map_out !== 16'h0) $display("FAIL hz_busy_clr got %h exp 0", busy_map_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL hz_inflight got %0d exp 0", inflight_out); else passes++;
      checks++; if (issue_grant_out !== 1'b1) $display("FAIL hz_dep_grant got %0b exp 1", issue_grant_out); else passes++;
      issue_valid_in = 0;
      tick();
      checks++; if (rf_we_out !== 1'b0) $display("FAIL hz_we_pulse got %0b exp 0", rf_we_out); else passes++;
   endtask

   task automatic test_special();
      issue_valid_in = 1; issue_dest_in = 0; issue_dest_valid_in = 1;
      issue_dest_special_in = 2; issue_dest_special_valid_in = 1;
      tick(); clr_inputs();
      checks++; if (busy_map_out !== 16'h0005) $display("FAIL sp_busy_set got %h exp 0005", busy_map_out); else passes++;
      drive_wb(4'd0, 4'd2, 1, 64'hA, 64'hB, 0);
      #1;
      checks++; if (wb_ready_out !== 1'b1) $display("FAIL sp_ready0 got %0b exp 1", wb_ready_out); else passes++;
      tick(); clr_inputs();
      checks++; if ({rf_we_out, rf_waddr_out, rf_wdata_out} !== {1'b1, 4'd0, 64'hA})
         $display("FAIL sp_main_write got we=%0b a=%0d d=%h exp we=1 a=0 d=a", rf_we_out, rf_waddr_out, rf_wdata_out); else passes++;
      checks++; if (wb_ready_out !== 1'b0) $display("FAIL sp_ready1 got %0b exp 0", wb_ready_out); else passes++;
      checks++; if (busy_map_out !== 16'h0004) $display("FAIL sp_busy_mid got %h exp 0004", busy_map_out); else passes++;
      tick();
      checks++; if ({rf_we_out, rf_waddr_out, rf_wdata_out} !== {1'b1, 4'd2, 64'hB})
         $display("FAIL sp_spec_write got we=%0b a=%0d d=%h exp we=1 a=2 d=b", rf_we_out, rf_waddr_out, rf_wdata_out); else passes++;
      checks++; if (busy_map_out !== 16'h0) $display("FAIL sp_busy_end got %h exp 0", busy_map_out); else passes++;
      checks++; if (wb_ready_out !== 1'b1) $display("FAIL sp_ready2 got %0b exp 1", wb_ready_out); else passes++;
      // special equal to main, accepted with nothing in flight
      drive_wb(4'd0, 4'd0, 1, 64'hA, 64'hB, 0);
      tick(); clr_inputs();
      checks++; if ({rf_we_out, rf_waddr_out, rf_wdata_out} !== {1'b1, 4'd0, 64'hA})
         $display("FAIL sp_same_write got we=%0b a=%0d d=%h exp we=1 a=0 d=a", rf_we_out, rf_waddr_out, rf_wdata_out); else passes++;
      checks++; if (wb_ready_out !== 1'b1) $display("FAIL sp_same_ready got %0b exp 1", wb_ready_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL sp_inflight_sat got %0d exp 0", inflight_out); else passes++;
      tick();
      checks++; if (rf_we_out !== 1'b0) $display("FAIL sp_same_single got %0b exp 0", rf_we_out); else passes++;
   endtask

   task automatic test_inflight_limit();
      for (int i = 0; i < 4; i++) begin
         drive_issue(4'(4 + i), 1, 4'd0, 0);
         #1;
         checks++; if (issue_grant_out !== 1'b1) $display("FAIL lim_grant%0d got %0b exp 1", i, issue_grant_out); else passes++;
         tick(); clr_inputs();
      end
      checks++; if (inflight_out !== 3'd4) $display("FAIL lim_full got %0d exp 4", inflight_out); else passes++;
      drive_issue(4'd8, 1, 4'd0, 0);
      drive_wb(4'd4, 4'd0, 0, 64'h44, 64'h0, 0);
      #1;
      checks++; if (issue_grant_out !== 1'b0) $display("FAIL lim_fifth got %0b exp 0", issue_grant_out); else passes++;
      tick(); clr_inputs();
      checks++; if (inflight_out !== 3'd3) $display("FAIL lim_after_wb got %0d exp 3", inflight_out); else passes++;
      drive_issue(4'd8, 1, 4'd0, 0);
      drive_wb(4'd5, 4'd0, 0, 64'h55, 64'h0, 0);
      #1;
      checks++; if (issue_grant_out !== 1'b1) $display("FAIL lim_simul_grant got %0b exp 1", issue_grant_out); else passes++;
      tick(); clr_inputs();
      checks++; if (inflight_out !== 3'd3) $display("FAIL lim_simul_cnt got %0d exp 3", inflight_out); else passes++;
      checks++; if (busy_map_out !== 16'h01C0) $display("FAIL lim_busy got %h exp 01c0", busy_map_out); else passes++;
   endtask

   task automatic test_flush();
      do_reset();
      drive_issue(4'd5, 1, 4'd0, 0);
      tick(); clr_inputs();
      drive_wb(4'd1, 4'd2, 1, 64'h11, 64'h22, 0);
      tick(); clr_inputs();
      flush_in = 1;
      #1;
      checks++; if (wb_ready_out !== 1'b0) $display("FAIL fl_ready_during got %0b exp 0", wb_ready_out); else passes++;
      tick();
      flush_in = 0;
      #1;
      checks++; if (rf_we_out !== 1'b0) $display("FAIL fl_no_spec_write got %0b exp 0", rf_we_out); else passes++;
      checks++; if (busy_map_out !== 16'h0) $display("FAIL fl_busy got %h exp 0", busy_map_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL fl_inflight got %0d exp 0", inflight_out); else passes++;
      checks++; if (wb_ready_out !== 1'b1) $display("FAIL fl_ready_after got %0b exp 1", wb_ready_out); else passes++;
      tick();
      checks++; if (rf_we_out !== 1'b0) $display("FAIL fl_no_late_write got %0b exp 0", rf_we_out); else passes++;
   endtask

   task automatic test_kill_halt();
      do_reset();
      drive_issue(4'd6, 1, 4'd0, 0);
      tick(); clr_inputs();
      drive_wb(4'd6, 4'd0, 0, 64'h66, 64'h0, 1);
      tick(); clr_inputs();
      checks++; if (halt_out !== 1'b1) $display("FAIL kh_halt got %0b exp 1", halt_out); else passes++;
      checks++; if (rf_we_out !== 1'b0) $display("FAIL kh_no_write got %0b exp 0", rf_we_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL kh_inflight got %0d exp 0", inflight_out); else passes++;
      drive_issue(4'd7, 1, 4'd0, 0);
      drive_wb(4'd6, 4'd0, 0, 64'h77, 64'h0, 0);
      #1;
      checks++; if (issue_grant_out !== 1'b0) $display("FAIL kh_grant got %0b exp 0", issue_grant_out); else passes++;
      checks++; if (wb_ready_out !== 1'b0) $display("FAIL kh_ready got %0b exp 0", wb_ready_out); else passes++;
      tick(); clr_inputs();
      checks++; if (busy_map_out !== 16'h0040) $display("FAIL kh_busy_frozen got %h exp 0040", busy_map_out); else passes++;
      checks++; if (rf_we_out !== 1'b0) $display("FAIL kh_no_write2 got %0b exp 0", rf_we_out); else passes++;
      flush_in = 1;
      tick();
      flush_in = 0;
      #1;
      checks++; if (halt_out !== 1'b1) $display("FAIL kh_flush_halt got %0b exp 1", halt_out); else passes++;
      checks++; if (wb_ready_out !== 1'b0) $display("FAIL kh_flush_ready got %0b exp 0", wb_ready_out); else passes++;
      do_reset();
      checks++; if (halt_out !== 1'b0) $display("FAIL kh_reset_halt got %0b exp 0", halt_out); else passes++;
   endtask

   task automatic test_async_reset();
      drive_issue(4'd3, 1, 4'd0, 0);
      tick(); clr_inputs();
      drive_issue(4'd9, 1, 4'd0, 0);
      tick(); clr_inputs();
      drive_wb(4'd3, 4'd0, 0, 64'hDEAD, 64'h0, 0);
      tick(); clr_inputs();
      checks++; if (rf_we_out !== 1'b1) $display("FAIL ar_pre_we got %0b exp 1", rf_we_out); else passes++;
      #2;
      reset_n = 0;
      #1;
      checks++; if (busy_map_out !== 16'h0) $display("FAIL ar_busy got %h exp 0", busy_map_out); else passes++;
      checks++; if (inflight_out !== 3'd0) $display("FAIL ar_inflight got %0d exp 0", inflight_out); else passes++;
      checks++; if ({rf_we_out, rf_waddr_out, rf_wdata_out} !== '0)
         $display("FAIL ar_rf got we=%0b a=%0d d=%h exp 0", rf_we_out, rf_waddr_out, rf_wdata_out); else passes++;
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   // Randomized run; the model tracks registers, an outstanding count and a pending special write.
   task automatic test_random();
      bit               busy[NR];
      int               cnt;
      bit               spec_pend;
      logic [AW-1:0]    spec_a;
      logic [DW-1:0]    spec_d;
      bit               e_grant, e_ready, accept, hz;
      logic [NR-1:0]    busy_vec;
      logic [AW+DW-1:0] got;
      do_reset();
      foreach (busy[r]) busy[r] = 0;
      cnt = 0; spec_pend = 0; spec_a = 0; spec_d = 0;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         issue_valid_in = ($urandom_range(0, 1) == 1);
         issue_src1_in = 4'($urandom_range(0, 15)); issue_src1_valid_in = 1'($urandom_range(0, 1));
         issue_src2_in = 4'($urandom_range(0, 15)); issue_src2_valid_in = 1'($urandom_range(0, 1));
         issue_dest_in = 4'($urandom_range(0, 15)); issue_dest_valid_in = 1'($urandom_range(0, 1));
         issue_dest_special_in = 4'($urandom_range(0, 15));
         issue_dest_special_valid_in = ($urandom_range(0, 3) == 0);
         wb_valid_in = ($urandom_range(0, 9) < 4);
         wb_kill_in = 0;
         wb_dest_in = 4'($urandom_range(0, 15));
         wb_dest_special_in = 4'($urandom_range(0, 15));
         wb_dest_special_valid_in = ($urandom_range(0, 2) == 0);
         wb_result_in = {$urandom, $urandom};
         wb_result_special_in = {$urandom, $urandom};
         flush_in = ($urandom_range(0, 24) == 0);
         #1;
         hz = (issue_src1_valid_in && busy[issue_src1_in]) || (issue_src2_valid_in && busy[issue_src2_in])
           || (issue_dest_valid_in && busy[issue_dest_in])
           || (issue_dest_special_valid_in && busy[issue_dest_special_in]);
         e_ready = !spec_pend && !flush_in;
         e_grant = issue_valid_in && !flush_in && (cnt < 4) && !hz;
         accept  = wb_valid_in && e_ready;
         checks++; if (issue_grant_out !== e_grant) $display("FAIL rnd_grant c=%0d got %0b exp %0b", c, issue_grant_out, e_grant); else passes++;
         checks++; if (wb_ready_out !== e_ready) $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, wb_ready_out, e_ready); else passes++;
         if (flush_in) begin
            foreach (busy[r]) busy[r] = 0;
            cnt = 0; spec_pend = 0;
         end else begin
            if (spec_pend) begin
               exp_q.push_back({spec_a, spec_d});
               busy[spec_a] = 0;
               spec_pend = 0;
            end else if (accept) begin
               exp_q.push_back({wb_dest_in, wb_result_in});
               busy[wb_dest_in] = 0;
               if (wb_dest_special_valid_in && wb_dest_special_in != wb_dest_in) begin
                  spec_pend = 1; spec_a = wb_dest_special_in; spec_d = wb_result_special_in;
               end
            end
            if (e_grant) begin
               if (issue_dest_valid_in) busy[issue_dest_in] = 1;
               if (issue_dest_special_valid_in) busy[issue_dest_special_in] = 1;
            end
            if (e_grant && !accept) cnt = cnt + 1;
            else if (!e_grant && accept && cnt > 0) cnt = cnt - 1;
         end
         tick();
         if (rf_we_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL rnd_spurious_write c=%0d got a=%0d exp none", c, rf_waddr_out);
            else begin
               got = exp_q.pop_front();
               if ({rf_waddr_out, rf_wdata_out} !== got)
                  $display("FAIL rnd_write c=%0d got %h exp %h", c, {rf_waddr_out, rf_wdata_out}, got);
               else passes++;
            end
         end else if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL rnd_missing_write c=%0d got we=%0b exp %h", c, rf_we_out, exp_q[0]);
            exp_q.delete();
         end
         foreach (busy[r]) busy_vec[r] = busy[r];
         checks++; if (busy_map_out !== busy_vec) $display("FAIL rnd_busy c=%0d got %h exp %h", c, busy_map_out, busy_vec); else passes++;
         checks++; if (inflight_out !== 3'(cnt)) $display("FAIL rnd_inflight c=%0d got %0d exp %0d", c, inflight_out, cnt); else passes++;
      end
      clr_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clr_inputs();
      test_reset();
      test_hazard();
      test_special();
      test_inflight_limit();
      test_flush();
      test_kill_halt();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
